// File: rtl/otter_mmio_bridge.sv
// MMIO bridge: decodes hart accesses at/above MEM_SIZE onto NUM_CH req/ack channels.
// Latency 3+ cycles (IDLE, WAIT_ACK..., DONE); io_stall freezes the hart until DONE.
module otter_mmio_bridge #(
  parameter int MEM_SIZE  = 2**16,
  parameter int NUM_CH    = 4,
  parameter int CH_STRIDE = 256,
  parameter int TIMEOUT   = 15
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [31:0]           dmem_addr,
  input  logic [31:0]           dmem_w_data,
  input  logic [3:0]            dmem_w_strb,
  input  logic                  dmem_w_en,
  input  logic                  dmem_r_en,
  output logic [31:0]           io_r_data,
  output logic                  io_stall,
  output logic                  io_err,
  output logic [NUM_CH*32-1:0]  io_out,
  output logic [31:0]           io_addr,
  output logic [NUM_CH-1:0]     io_wr,
  output logic [NUM_CH-1:0]     io_rd,
  input  logic [NUM_CH*32-1:0]  io_in,
  input  logic [NUM_CH-1:0]     io_ack
);
  localparam int SHIFT = $clog2(CH_STRIDE);
  localparam int CHW   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  typedef enum logic [1:0] {IDLE, WAIT_ACK, DONE} state_t;

  state_t                 state_q;
  logic [CHW-1:0]         ch_q;
  logic [7:0]             cnt_q;
  logic                   err_q;
  logic [31:0]            rdata_q;
  logic [31:0]            addr_q;
  logic [NUM_CH*32-1:0]   out_q;
  logic [NUM_CH-1:0]      wr_q;
  logic [NUM_CH-1:0]      rd_q;

  logic                   hit;
  logic [31:0]            off;
  logic [31:0]            ch_full;
  logic                   ch_ok;
  logic [CHW-1:0]         ch_sel;
  logic [31:0]            wdat_m;
  logic [NUM_CH-1:0]      oh;
  logic [NUM_CH*32-1:0]   out_next;
  logic                   ack_sel;
  logic [31:0]            in_sel;

  always_comb begin
    hit     = (dmem_w_en | dmem_r_en) & (dmem_addr >= 32'(MEM_SIZE));
    off     = dmem_addr - 32'(MEM_SIZE);
    ch_full = off >> SHIFT;
    ch_ok   = ch_full < 32'(NUM_CH);
    ch_sel  = ch_full[CHW-1:0];
    for (int b = 0; b < 4; b++) begin
      wdat_m[b*8 +: 8] = dmem_w_strb[b] ? dmem_w_data[b*8 +: 8] : 8'h00;
    end
    oh       = '0;
    out_next = '0;
    ack_sel  = 1'b0;
    in_sel   = 32'h0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (ch_sel == CHW'(k)) begin
        oh[k]             = 1'b1;
        out_next[k*32 +: 32] = wdat_m;
      end
      // Only the latched channel may complete the transaction.
      if (ch_q == CHW'(k)) begin
        ack_sel = io_ack[k];
        in_sel  = io_in[k*32 +: 32];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ch_q    <= '0;
      cnt_q   <= 8'h0;
      err_q   <= 1'b0;
      rdata_q <= 32'h0;
      addr_q  <= 32'h0;
      out_q   <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (hit) begin
            if (ch_ok) begin
              ch_q    <= ch_sel;
              addr_q  <= off & 32'(CH_STRIDE - 1);
              out_q   <= out_next;
              wr_q    <= dmem_w_en ? oh : '0;
              rd_q    <= dmem_w_en ? '0 : oh;
              cnt_q   <= 8'h0;
              state_q <= WAIT_ACK;
            end else begin
              err_q   <= 1'b1;
              rdata_q <= 32'h0;
              state_q <= DONE;
            end
          end
        end
        WAIT_ACK: begin
          if (ack_sel) begin
            rdata_q <= (|wr_q) ? 32'h0 : in_sel;
            wr_q    <= '0;
            rd_q    <= '0;
            state_q <= DONE;
          end else if (cnt_q == 8'(TIMEOUT - 1)) begin
            // TIMEOUT wait cycles elapsed without a completion.
            wr_q    <= '0;
            rd_q    <= '0;
            err_q   <= 1'b1;
            rdata_q <= 32'h0;
            state_q <= DONE;
          end else begin
            cnt_q <= cnt_q + 8'h1;
          end
        end
        DONE: begin
          err_q   <= 1'b0;
          wr_q    <= '0;
          rd_q    <= '0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign io_stall  = ((state_q == IDLE) & hit) | (state_q == WAIT_ACK);
  assign io_r_data = rdata_q;
  assign io_err    = err_q;
  assign io_out    = out_q;
  assign io_addr   = addr_q;
  assign io_wr     = wr_q;
  assign io_rd     = rd_q;
endmodule

// File: tb/tb_otter_mmio_bridge.sv
// Bench for otter_mmio_bridge: directed scenarios plus random accesses checked
// against a transaction-level model of decode, stall length and completion.
module tb_otter_mmio_bridge;
  localparam logic [31:0] MEM = 32'h0001_0000;
  localparam int NUM = 4;
  localparam int STRIDE = 256;
  localparam int TO = 15;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [31:0]  dmem_addr, dmem_w_data;
  logic [3:0]   dmem_w_strb;
  logic         dmem_w_en, dmem_r_en;
  logic [31:0]  io_r_data;
  logic         io_stall, io_err;
  logic [127:0] io_out;
  logic [31:0]  io_addr;
  logic [3:0]   io_wr, io_rd;
  logic [127:0] io_in;
  logic [3:0]   io_ack;

  int n_chk = 0;
  int n_err = 0;

  logic [127:0] m_out;
  logic [31:0]  m_addr, m_rdata;

  otter_mmio_bridge dut (
    .clk(clk), .rst_n(rst_n), .dmem_addr(dmem_addr), .dmem_w_data(dmem_w_data),
    .dmem_w_strb(dmem_w_strb), .dmem_w_en(dmem_w_en), .dmem_r_en(dmem_r_en),
    .io_r_data(io_r_data), .io_stall(io_stall), .io_err(io_err), .io_out(io_out),
    .io_addr(io_addr), .io_wr(io_wr), .io_rd(io_rd), .io_in(io_in), .io_ack(io_ack)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called at posedge+1; returns at posedge+1 of the IDLE cycle after completion.
  task automatic access(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] st,
                        input logic we, input logic re, input int d);
    logic [127:0] in_v;
    logic [31:0]  off, ch;
    logic         hit, valid, exp_err;
    logic [3:0]   exp_wr, exp_rd, own;
    int           exp_stall, c, sn;
    bit           done;
    in_v = {$urandom, $urandom, $urandom, $urandom};
    io_in = in_v;
    dmem_addr = a; dmem_w_data = wd; dmem_w_strb = st; dmem_w_en = we; dmem_r_en = re;
    hit = (we | re) && (a >= MEM);
    off = a - MEM;
    ch = off / STRIDE;
    valid = hit && (ch < NUM);
    exp_wr = 4'h0; exp_rd = 4'h0; exp_err = 1'b0; exp_stall = 0; own = 4'h0;
    if (hit && !valid) begin
      exp_stall = 1; exp_err = 1'b1; m_rdata = 32'h0;
    end else if (valid) begin
      own = 4'b0001 << ch;
      m_addr = off % STRIDE;
      m_out = '0;
      for (int b = 0; b < 4; b++)
        if (st[b]) m_out[ch*32 + b*8 +: 8] = wd[b*8 +: 8];
      if (we) exp_wr = own; else exp_rd = own;
      if (d >= 1 && d <= TO) begin
        exp_stall = d + 1;
        m_rdata = we ? 32'h0 : in_v[ch*32 +: 32];
      end else begin
        exp_stall = TO + 1; exp_err = 1'b1; m_rdata = 32'h0;
      end
    end
    c = 0; sn = 0; done = 0;
    while (!done && c < 300) begin
      @(negedge clk);
      if (io_stall) begin
        sn++;
        if (c == 0) begin
          chk("idle_wr", io_wr, 0);
          chk("idle_rd", io_rd, 0);
        end else begin
          chk("req_wr", io_wr, exp_wr);
          chk("req_rd", io_rd, exp_rd);
          chk("req_out", io_out, m_out);
          chk("req_addr", io_addr, m_addr);
        end
      end else begin
        done = 1;
        chk("stall_cycles", sn, exp_stall);
        chk("err", io_err, exp_err);
        chk("rdata", io_r_data, m_rdata);
        chk("done_wr", io_wr, 0);
        chk("done_rd", io_rd, 0);
        chk("done_out", io_out, m_out);
        chk("done_addr", io_addr, m_addr);
      end
      @(posedge clk); #1;
      c++;
      if (done) begin
        io_ack = 4'h0; dmem_w_en = 1'b0; dmem_r_en = 1'b0;
      end else begin
        // Wrong-channel noise plus an owner ack that stays high once raised.
        io_ack = (4'($urandom_range(0, 15)) & ~own) | ((d != 0 && c >= d) ? own : 4'h0);
      end
    end
    if (!done) chk("bound", 0, 1);
  endtask

  initial begin
    logic [31:0] a;
    int sel, kind;
    rst_n = 1'b0; io_ack = 4'h0; io_in = '0;
    dmem_addr = 32'h0001_0000; dmem_w_data = 32'h1234_5678; dmem_w_strb = 4'hF;
    dmem_w_en = 1'b1; dmem_r_en = 1'b0;
    m_out = '0; m_addr = 32'h0; m_rdata = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_wr", io_wr, 0);
    chk("rst_rd", io_rd, 0);
    chk("rst_out", io_out, 0);
    chk("rst_addr", io_addr, 0);
    chk("rst_rdata", io_r_data, 0);
    chk("rst_err", io_err, 0);
    chk("rst_stall", io_stall, 1);
    @(posedge clk); #1;
    rst_n = 1'b1; dmem_w_en = 1'b0;

    access(32'h0001_0204, 32'hAABB_CCDD, 4'b0101, 1'b1, 1'b0, 1);
    chk("wr_ch2_lane", m_out[95:64], 32'h00BB_00DD);
    access(32'h0001_0100, 32'h0, 4'h0, 1'b0, 1'b1, 5);
    access(32'h0001_0300, 32'h0, 4'h0, 1'b0, 1'b1, 0);
    access(32'h0001_0400, 32'hDEAD_BEEF, 4'hF, 1'b1, 1'b0, 1);
    access(32'h0000_FFFC, 32'hDEAD_BEEF, 4'hF, 1'b1, 1'b0, 1);
    access(32'h0001_03FC, 32'h5555_AAAA, 4'hF, 1'b1, 1'b1, TO);

    for (int i = 0; i < 40; i++) begin
      sel = $urandom_range(0, 5);
      case (sel)
        0: a = 32'($urandom_range(0, 32'hFFFF));
        4: a = MEM + 32'(NUM * STRIDE) + 32'($urandom_range(0, 4095));
        5: a = $urandom | 32'h8000_0000;
        default: a = MEM + 32'($urandom_range(0, NUM - 1) * STRIDE) + 32'($urandom_range(0, 255));
      endcase
      kind = $urandom_range(0, 4);
      access(a, $urandom, 4'($urandom_range(0, 15)), kind[0] | (kind == 4), kind[1],
             $urandom_range(0, TO + 2));
    end

    // Reset during WAIT_ACK on ch0 after an ignored ack on ch1.
    io_in = {96'h0, 32'hCAFE_F00D};
    dmem_addr = 32'h0001_0000; dmem_w_en = 1'b0; dmem_r_en = 1'b1;
    @(negedge clk);
    chk("mid_hit_stall", io_stall, 1);
    @(posedge clk); #1; io_ack = 4'b0010;
    @(negedge clk);
    chk("mid_rd", io_rd, 4'b0001);
    @(posedge clk); #1; io_ack = 4'b0000;
    @(negedge clk);
    chk("mid_rd_after_wrong_ack", io_rd, 4'b0001);
    chk("mid_stall_after_wrong_ack", io_stall, 1);
    @(posedge clk); #1; rst_n = 1'b0;
    @(posedge clk); #1; rst_n = 1'b1; dmem_r_en = 1'b0; io_ack = 4'b0001;
    @(negedge clk);
    chk("mid_rst_rd", io_rd, 0);
    chk("mid_rst_rdata", io_r_data, 0);
    chk("mid_rst_stall", io_stall, 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("late_ack_rdata", io_r_data, 0);
    chk("late_ack_err", io_err, 0);
    chk("late_ack_rd", io_rd, 0);
    io_ack = 4'h0;

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
